// File: rtl/bcd_timer.sv
// Six-digit BCD stopwatch / countdown timer (HH:MM:SS).
// A prescaler divides clk down to one-second ticks. The hour modulus is configurable.
// The timer supports preload, up and down counting, and a lap-capture FIFO.
// The lap FIFO is a shift register with its head in entry 0, so lap_time comes
// straight from a flop.
module bcd_timer #(
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned HOURS_WRAP = 24,
    parameter int unsigned LAP_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             clear,
    input  logic                             load,
    input  logic [23:0]                      load_time,
    input  logic                             mode,
    input  logic                             lap,
    input  logic                             lap_rd,
    output logic [23:0]                      time_out,
    output logic                             running,
    output logic                             expired,
    output logic                             load_err,
    output logic                             lap_valid,
    output logic [23:0]                      lap_time,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
    output logic                             lap_ovf
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CW = $clog2(LAP_DEPTH + 1);

    localparam logic [PW-1:0] PresLast  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PresOne   = PW'(1);
    localparam logic [7:0]    HourLast  = 8'(HOURS_WRAP - 1);
    localparam logic [7:0]    HourLimit = 8'(HOURS_WRAP);
    localparam logic [3:0]    WrapMsb   = 4'((HOURS_WRAP - 1) / 10);
    localparam logic [3:0]    WrapLsb   = 4'((HOURS_WRAP - 1) % 10);
    localparam logic [CW-1:0] CntFull   = CW'(LAP_DEPTH);
    localparam logic [CW-1:0] CntOne    = CW'(1);

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // Binary value of a two-digit BCD hour field. Illegal digits still fit in 8 bits.
    function automatic logic [7:0] hour_value(input logic [3:0] msb, input logic [3:0] lsb);
        return ({4'd0, msb} * 8'd10) + {4'd0, lsb};
    endfunction

    function automatic logic load_legal(input logic [23:0] t);
        return (t[3:0]   <= 4'd9) &&
               (t[7:4]   <= 4'd5) &&
               (t[11:8]  <= 4'd9) &&
               (t[15:12] <= 4'd5) &&
               (t[19:16] <= 4'd9) &&
               (t[23:20] <= 4'd9) &&
               (hour_value(t[23:20], t[19:16]) < HourLimit);
    endfunction

    // Ripple-carry increment. The hour wraps from HOURS_WRAP-1 back to 00.
    function automatic logic [23:0] bcd_up(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 != 4'd5) begin
                        m1 = m1 + 4'd1;
                    end else begin
                        m1 = 4'd0;
                        if (hour_value(h1, h0) == HourLast) begin
                            h1 = 4'd0;
                            h0 = 4'd0;
                        end else if (h0 != 4'd9) begin
                            h0 = h0 + 4'd1;
                        end else begin
                            h0 = 4'd0;
                            h1 = h1 + 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    // Ripple-borrow decrement. The hour borrows from 00 to HOURS_WRAP-1.
    function automatic logic [23:0] bcd_down(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    if (m1 != 4'd0) begin
                        m1 = m1 - 4'd1;
                    end else begin
                        m1 = 4'd5;
                        if ((h1 == 4'd0) && (h0 == 4'd0)) begin
                            h1 = WrapMsb;
                            h0 = WrapLsb;
                        end else if (h0 != 4'd0) begin
                            h0 = h0 - 4'd1;
                        end else begin
                            h0 = 4'd9;
                            h1 = h1 - 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    // ------------------------------------------------------------------
    // Timer core
    // ------------------------------------------------------------------

    logic [23:0]   time_q, time_d;
    logic          running_q, running_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          expired_q, expired_d;
    logic          load_err_q, load_err_d;

    logic          tick;
    logic [23:0]   time_dec;
    logic [23:0]   time_adv;
    logic          running_adv;
    logic [PW-1:0] presc_adv;
    logic          expired_adv;

    assign tick     = running_q && (presc_q == PresLast);
    assign time_dec = bcd_down(time_q);

    // Free-running behaviour for a cycle with no effective control strobe.
    always_comb begin
        time_adv    = time_q;
        running_adv = running_q;
        presc_adv   = presc_q;
        expired_adv = 1'b0;
        if (tick) begin
            presc_adv = '0;
            if (mode) begin
                time_adv = time_dec;
                if (time_dec == 24'd0) begin
                    running_adv = 1'b0;
                    expired_adv = 1'b1;
                end
            end else begin
                time_adv = bcd_up(time_q);
            end
        end else if (running_q) begin
            presc_adv = presc_q + PresOne;
        end
    end

    // Control strobes in priority order: clear > load > stop > start.
    always_comb begin
        time_d     = time_q;
        running_d  = running_q;
        presc_d    = presc_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            time_d    = '0;
            running_d = 1'b0;
            presc_d   = '0;
        end else if (load) begin
            if (load_legal(load_time)) begin
                time_d    = load_time;
                running_d = 1'b0;
                presc_d   = '0;
            end else begin
                // A rejected load consumes the cycle: time, prescaler and running all hold.
                load_err_d = 1'b1;
            end
        end else if (stop) begin
            running_d = 1'b0;
        end else if (start && !running_q) begin
            // A down-count cannot start from zero.
            if (!(mode && (time_q == 24'd0))) begin
                running_d = 1'b1;
                presc_d   = '0;
            end
        end else begin
            time_d    = time_adv;
            running_d = running_adv;
            presc_d   = presc_adv;
            expired_d = expired_adv;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_q     <= '0;
            running_q  <= 1'b0;
            presc_q    <= '0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            time_q     <= time_d;
            running_q  <= running_d;
            presc_q    <= presc_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Lap FIFO
    // ------------------------------------------------------------------
    // Entry 0 is the head. A pop shifts every entry down and fills the top with zero.
    // Entries at or above count are therefore always zero.

    logic [23:0]   fifo_q [LAP_DEPTH];
    logic [23:0]   fifo_d [LAP_DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          valid_q;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          pop_ok;
    logic          push_ok;
    logic [CW-1:0] wr_idx;

    assign full    = (count_q == CntFull);
    assign pop_ok  = lap_rd && (count_q != '0);
    assign push_ok = lap && (!full || pop_ok);
    assign wr_idx  = pop_ok ? (count_q - CntOne) : count_q;

    // FIFO next state. A push captures time_q, the value visible in this cycle.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                fifo_d[i] = '0;
            end
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (pop_ok) begin
                for (int unsigned i = 0; i + 1 < LAP_DEPTH; i++) begin
                    fifo_d[i] = fifo_q[i+1];
                end
                fifo_d[LAP_DEPTH-1] = '0;
            end
            if (push_ok) begin
                for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        fifo_d[i] = time_q;
                    end
                end
            end
            if (lap && full && !pop_ok) begin
                ovf_d = 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO registers. lap_valid is kept as its own flop so every output is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
            ovf_q   <= ovf_d;
        end
    end

    assign time_out  = time_q;
    assign running   = running_q;
    assign expired   = expired_q;
    assign load_err  = load_err_q;
    assign lap_valid = valid_q;
    assign lap_time  = fifo_q[0];
    assign lap_count = count_q;
    assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Bench for bcd_timer: directed steps followed by random strobes. Every cycle is checked
// against a model that keeps time as plain seconds and the lap FIFO as a queue.
module tb_bcd_timer;

    localparam int unsigned CLK_DIV    = 3;
    localparam int unsigned HOURS_WRAP = 12;
    localparam int unsigned LAP_DEPTH  = 4;
    localparam int unsigned CW         = $clog2(LAP_DEPTH + 1);
    localparam int          TOTAL      = HOURS_WRAP * 3600;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [23:0]   load_time = '0;
    logic          mode = 1'b0, lap = 1'b0, lap_rd = 1'b0;
    logic [23:0]   time_out;
    logic          running, expired, load_err, lap_valid, lap_ovf;
    logic [23:0]   lap_time;
    logic [CW-1:0] lap_count;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state.
    int          m_secs;
    bit          m_run;
    int          m_presc;
    bit          m_exp;
    bit          m_lerr;
    bit          m_ovf;
    logic [23:0] m_laps[$];

    bcd_timer #(
        .CLK_DIV    (CLK_DIV),
        .HOURS_WRAP (HOURS_WRAP),
        .LAP_DEPTH  (LAP_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .load      (load),
        .load_time (load_time),
        .mode      (mode),
        .lap       (lap),
        .lap_rd    (lap_rd),
        .time_out  (time_out),
        .running   (running),
        .expired   (expired),
        .load_err  (load_err),
        .lap_valid (lap_valid),
        .lap_time  (lap_time),
        .lap_count (lap_count),
        .lap_ovf   (lap_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int from_bcd(input logic [23:0] t);
        return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
               (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
               int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic bit legal(input logic [23:0] t);
        int hour;
        hour = int'(t[23:20]) * 10 + int'(t[19:16]);
        return t[3:0] <= 9 && t[7:4] <= 5 && t[11:8] <= 9 && t[15:12] <= 5 &&
               t[19:16] <= 9 && t[23:20] <= 9 && hour < HOURS_WRAP;
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_run   = 0;
        m_presc = 0;
        m_exp   = 0;
        m_lerr  = 0;
        m_ovf   = 0;
        m_laps.delete();
    endtask

    // One second of counting, if this cycle is a tick.
    task automatic model_advance();
        if (m_run) begin
            if (m_presc == CLK_DIV - 1) begin
                m_presc = 0;
                if (mode) begin
                    m_secs = (m_secs == 0) ? TOTAL - 1 : m_secs - 1;
                    if (m_secs == 0) begin
                        m_run = 0;
                        m_exp = 1;
                    end
                end else begin
                    m_secs = (m_secs + 1) % TOTAL;
                end
            end else begin
                m_presc++;
            end
        end
    endtask

    // Applies the inputs seen at a rising edge.
    task automatic model_edge();
        logic [23:0] shown;
        shown  = to_bcd(m_secs);
        m_exp  = 0;
        m_lerr = 0;
        if (clear) begin
            m_laps.delete();
            m_ovf = 0;
        end else begin
            if (lap_rd && m_laps.size() > 0) void'(m_laps.pop_front());
            if (lap) begin
                if (m_laps.size() < LAP_DEPTH) m_laps.push_back(shown);
                else m_ovf = 1;
            end
        end
        if (clear) begin
            m_secs  = 0;
            m_run   = 0;
            m_presc = 0;
        end else if (load) begin
            if (legal(load_time)) begin
                m_secs  = from_bcd(load_time);
                m_run   = 0;
                m_presc = 0;
            end else begin
                m_lerr = 1;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (start && !m_run) begin
            if (!(mode && m_secs == 0)) begin
                m_run   = 1;
                m_presc = 0;
            end
        end else begin
            model_advance();
        end
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("time_out", time_out, to_bcd(m_secs));
        check("running", 24'(running), 24'(m_run));
        check("expired", 24'(expired), 24'(m_exp));
        check("load_err", 24'(load_err), 24'(m_lerr));
        check("lap_valid", 24'(lap_valid), 24'(m_laps.size() > 0));
        check("lap_time", lap_time, (m_laps.size() > 0) ? m_laps[0] : 24'h0);
        check("lap_count", 24'(lap_count), 24'(m_laps.size()));
        check("lap_ovf", 24'(lap_ovf), 24'(m_ovf));
    endtask

    task automatic idle();
        start  = 0;
        stop   = 0;
        clear  = 0;
        load   = 0;
        lap    = 0;
        lap_rd = 0;
    endtask

    // One clock edge with the currently driven strobes, then release them.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        idle();
    endtask

    task automatic do_load(input logic [23:0] t);
        load_time = t;
        load      = 1;
        step();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 0;

        // Up count across the minute boundary, then a stop coinciding with a tick.
        do_load(24'h000058);
        start = 1;
        step();
        repeat (7) step();
        check("plan.up_minute", time_out, 24'h000100);
        step();
        stop = 1;
        step();
        check("plan.stop_hold", time_out, 24'h000100);
        start = 1;
        step();
        repeat (3) step();
        check("plan.restart_prescale", time_out, 24'h000101);

        // Hour wrap keeps running.
        do_load(24'h115958);
        start = 1;
        step();
        repeat (6) step();
        check("plan.wrap_time", time_out, 24'h000000);
        check("plan.wrap_running", 24'(running), 24'd1);

        // Rejected loads leave the time alone.
        stop = 1;
        step();
        do_load(24'h006100);
        check("plan.load_err_min", 24'(load_err), 24'd1);
        do_load(24'h120000);
        check("plan.load_err_hour", 24'(load_err), 24'd1);
        do_load(24'h00005A);
        step();

        // Down count to expiry, then start at zero is ignored.
        mode = 1;
        do_load(24'h000002);
        start = 1;
        step();
        repeat (6) step();
        check("plan.expired", 24'(expired), 24'd1);
        check("plan.expired_run", 24'(running), 24'd0);
        step();
        start = 1;
        step();
        check("plan.start_ignored", 24'(running), 24'd0);

        // Switching to down at zero while running wraps to the last hour.
        mode  = 0;
        start = 1;
        step();
        step();
        mode = 1;
        repeat (3) step();
        check("plan.down_wrap", time_out, 24'h115959);
        stop = 1;
        step();

        // Lap FIFO: overflow, push+pop while full, drain, clear with a lap.
        mode  = 0;
        clear = 1;
        step();
        start = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            lap = 1;
            step();
            step();
        end
        check("plan.lap_full", 24'(lap_count), 24'd4);
        check("plan.lap_ovf", 24'(lap_ovf), 24'd1);
        lap    = 1;
        lap_rd = 1;
        step();
        check("plan.pushpop_full", 24'(lap_count), 24'd4);
        for (int i = 0; i < 2; i++) begin
            lap_rd = 1;
            step();
        end
        lap   = 1;
        clear = 1;
        step();
        check("plan.clear_fifo", 24'(lap_count), 24'd0);

        // Asynchronous reset mid-run.
        start = 1;
        step();
        repeat (4) step();
        #2;
        reset = 1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 0;
        step();
        clear = 1;
        start = 1;
        step();
        check("plan.clear_start", 24'(running), 24'd0);

        // Random strobes.
        for (int n = 0; n < 4000; n++) begin
            clear = ($urandom_range(0, 99) < 2);
            load  = ($urandom_range(0, 99) < 5);
            stop  = ($urandom_range(0, 99) < 6);
            start = ($urandom_range(0, 99) < 15);
            lap   = ($urandom_range(0, 99) < 15);
            lap_rd = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 3) mode = ~mode;
            case ($urandom_range(0, 3))
                0:       load_time = to_bcd(int'($urandom_range(0, 5)));
                1:       load_time = to_bcd(TOTAL - 1 - int'($urandom_range(0, 3)));
                2:       load_time = to_bcd(int'($urandom_range(0, TOTAL - 1)));
                default: load_time = 24'($urandom());
            endcase
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised six-digit BCD stopwatch/countdown timer (HH:MM:SS) with a programmable tick prescaler, configurable hour wrap, preload, up/down mode and a lap-capture FIFO. It replaces the fixed 24-hour up-only stopwatch used by the display and control path. It drives the seven-segment digit muxes directly from `time_out` and is controlled by synchronous single-cycle command strobes.

## Interface
- `CLK_DIV`, 1: clk cycles per one-second tick; ≥1.
- `HOURS_WRAP`, 24: hour modulus; legal range 1..99.
- `LAP_DEPTH`, 4: lap FIFO entries; ≥1.
- `clk` in 1: clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin counting.
- `stop` in 1: freeze counting.
- `clear` in 1: zero time, stop, flush FIFO, clear `lap_ovf`.
- `load` in 1: preload `load_time`; stops the timer.
- `load_time` in 24: {hr_msb, hr_lsb, min_msb, min_lsb, sec_msb, sec_lsb}, 4 bits per digit.
- `mode` in 1: 0 = count up, 1 = count down.
- `lap` in 1: capture current time into the FIFO.
- `lap_rd` in 1: pop the FIFO head.
- `time_out` out 24: current time, same packing as `load_time`.
- `running` out 1: timer active.
- `expired` out 1: one-cycle pulse when a down-count reaches 00:00:00.
- `load_err` out 1: one-cycle pulse when a load is rejected.
- `lap_valid` out 1: FIFO non-empty.
- `lap_time` out 24: FIFO head (first-word fall-through).
- `lap_count` out $clog2(LAP_DEPTH+1): FIFO occupancy.
- `lap_ovf` out 1: sticky flag, set when a capture is dropped because the FIFO is full.

## Operation
- Reset values: `time_out`=0, `running`=0, `expired`=0, `load_err`=0, `lap_valid`=0, `lap_time`=0, `lap_count`=0, `lap_ovf`=0, prescaler=0.
- Control priority each cycle: `clear` > `load` > `stop` > `start`. Lower-priority control strobes in the same cycle are ignored. `lap` and `lap_rd` are independent of the control strobes.
- `start` while stopped:
  - Sets `running` and resets the prescaler to 0.
  - In down mode with time = 00:00:00, `start` is ignored.
  - `start` while already running has no effect.
- `stop` clears `running`. Prescaler and time are held.
- `load` validation:
  - A load is legal when every digit passes: sec_lsb≤9, sec_msb≤5, min_lsb≤9, min_msb≤5, hr_lsb≤9, hr_msb≤9, and the BCD hour value < HOURS_WRAP.
  - Legal load: time ← `load_time`, `running`←0, prescaler←0.
  - Illegal load: time unchanged, `running` unchanged, `load_err` pulses.
- Tick: occurs when `running`=1 and prescaler = CLK_DIV-1. The prescaler then wraps to 0; otherwise it increments while running.
- Up-count on tick:
  - Ripple-carry BCD increment: sec_lsb 9→0 carries into sec_msb; sec_msb 5→0 carries into minutes; minutes likewise carry into hours.
  - Hours wrap from (HOURS_WRAP-1):59:59 to 00:00:00. Counting continues.
- Down-count on tick:
  - BCD decrement with borrows: 0 borrows to 9 on lsb digits and to 5 on the sec/min msb digits. Hours borrow wraps 00 to HOURS_WRAP-1 (only reachable through the mid-run mode change below).
  - When the result is 00:00:00: `running`←0 and `expired` pulses in the same cycle the time becomes 0.
- `mode` is sampled at every tick and may change while running. Changing to down mode at time 0 while running decrements to (HOURS_WRAP-1):59:59.
- Lap FIFO:
  - `lap` pushes the pre-edge `time_out` value, i.e. the value visible in the cycle `lap` is asserted.
  - Push when full: entry dropped, `lap_ovf`←1.
  - `lap_rd` when `lap_valid`=1: pops the head. `lap_rd` when empty is ignored.
  - Simultaneous push and pop: legal at any occupancy, including full. `lap_count` is unchanged and the new entry is accepted.
  - `clear` flushes the FIFO. `lap` in the same cycle as `clear` is discarded.

## Timing
- All outputs are registered. Commands take effect on the edge at which they are sampled high.
- `start` sampled at edge N: `running`=1 after N. The first tick updates `time_out` at edge N+CLK_DIV, then every CLK_DIV edges.
- `stop` at edge M: no tick at M or later. A tick coinciding with `stop` is suppressed.
- Lap push visible (`lap_valid`, `lap_count`) one edge after `lap`. `lap_time` reflects the new head the edge after a pop.
- Asynchronous `reset` mid-count forces all reset values immediately. Counting resumes only on a new `start`.

## Test plan
- CLK_DIV=1, load 00:00:58, start → `time_out` 00:00:59, then 00:01:00 on consecutive edges; 23:59:59 + tick → 00:00:00 with `running` still 1.
- CLK_DIV=4, start at edge N → first increment at N+4, next at N+8; `stop` at N+6 holds the value, and the next `start` restarts the 4-cycle prescale.
- mode=1, load 00:01:00, start → 00:00:59 … 00:00:00; `expired` pulses once with the final value and `running`=0; a further `start` is ignored.
- Load 00:61:00 → `load_err` pulse, time unchanged; HOURS_WRAP=12, load 12:00:00 → rejected; 11:59:59 + tick → 00:00:00.
- LAP_DEPTH=4: five `lap` strobes → `lap_count`=4, `lap_ovf`=1. Pops return the first four times in order. Push+pop when full keeps `lap_count`=4 and accepts the new entry. `clear` → `lap_count`=0, `lap_ovf`=0.
- Assert `reset` mid-run with CLK_DIV=3 → all outputs 0 immediately; `clear`+`start` in the same cycle → time 0, `running`=0.
